// File: rtl/mod_mult_pkg.sv
// Shared widths, FSM state encoding and fixed latency for the 8-bit interleaved modular multiplier.
package mod_mult_pkg;
  localparam int WIDTH     = 8;
  localparam int CNT_W     = 3;
  localparam int FIXED_LAT = 33;

  typedef enum logic [2:0] {
    IDLE,
    DBL,
    RED1,
    ADD,
    RED2,
    DONE
  } state_t;
endpackage

// File: rtl/mm_addsub8.sv
// Combinational 8-bit add/subtract built on an explicit look-ahead carry network.
// sub=1 computes x + ~y + 1, so c8 doubles as the unsigned x >= y flag.
module mm_addsub8
  import mod_mult_pkg::*;
(
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             c8
);
  logic [WIDTH-1:0] y_eff;
  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] g;
  logic [WIDTH:0]   c;
  logic             acc;
  logic             prop;

  always_comb begin
    y_eff = sub ? ~y : y;
    p     = x ^ y_eff;
    g     = x & y_eff;
    c     = '0;
    c[0]  = sub;
    acc   = 1'b0;
    prop  = 1'b0;
    // Each carry is the flat OR of generate terms gated by the propagate runs above them.
    for (int i = 0; i < WIDTH; i++) begin
      acc  = g[i];
      prop = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        acc  = acc | (prop & g[j]);
        prop = prop & p[j];
      end
      c[i+1] = acc | (prop & c[0]);
    end
    sum = p ^ c[WIDTH-1:0];
    c8  = c[WIDTH];
  end
endmodule

// File: rtl/mod_mult_seq.sv
// Sequential MSB-first interleaved modular multiplier: result = (a*b) mod n, one op in flight.
// MOD_MULT_FAST_EN skips the add/reduce pair for zero multiplier bits; default build is constant-time.
module mod_mult_seq
  import mod_mult_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] n,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result
);
  state_t           state_q, state_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH:0]   t_q, t_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] n_q, n_d;

  logic [WIDTH-1:0] as_x;
  logic [WIDTH-1:0] as_y;
  logic             as_sub;
  logic [WIDTH-1:0] as_sum;
  logic             as_c8;
  logic [WIDTH-1:0] red_val;

  always_comb begin
    as_x   = r_q;
    as_y   = r_q;
    as_sub = 1'b0;
    case (state_q)
      ADD: as_y = b_q[cnt_q] ? a_q : '0;
      RED1, RED2: begin
        as_x   = t_q[WIDTH-1:0];
        as_y   = n_q;
        as_sub = 1'b1;
      end
      default: ;
    endcase
  end

  mm_addsub8 u_addsub (
    .x   (as_x),
    .y   (as_y),
    .sub (as_sub),
    .sum (as_sum),
    .c8  (as_c8)
  );

  // T < 2n always holds, so one conditional subtract fully reduces it.
  assign red_val = (t_q[WIDTH] | as_c8) ? as_sum : t_q[WIDTH-1:0];

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    t_d     = t_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    n_d     = n_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          n_d     = n;
          r_d     = '0;
          cnt_d   = CNT_W'(WIDTH - 1);
          state_d = DBL;
        end
      end
      DBL: begin
        t_d     = {as_c8, as_sum};
        state_d = RED1;
      end
      RED1: begin
        r_d     = red_val;
        state_d = ADD;
`ifdef MOD_MULT_FAST_EN
        if (!b_q[cnt_q]) begin
          if (cnt_q == '0) begin
            state_d = DONE;
          end else begin
            cnt_d   = cnt_q - CNT_W'(1);
            state_d = DBL;
          end
        end
`endif
      end
      ADD: begin
        t_d     = {as_c8, as_sum};
        state_d = RED2;
      end
      RED2: begin
        r_d = red_val;
        if (cnt_q == '0) begin
          state_d = DONE;
        end else begin
          cnt_d   = cnt_q - CNT_W'(1);
          state_d = DBL;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      r_q     <= '0;
      t_q     <= '0;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      n_q     <= '0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      t_q     <= t_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      n_q     <= n_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = out_valid ? r_q : '0;
endmodule

// File: tb/tb_mod_mult_seq.sv
// Scoreboard bench for mod_mult_seq: directed cases plus a randomized sweep against (a*b)%n.
module tb_mod_mult_seq;
  import mod_mult_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic [7:0] n = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] result;

  mod_mult_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .n         (n),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_res_q[$];
  int exp_lat_q[$];
  int or_mode = 0;  // 0: always ready, 1: never ready, 2: random
  int cyc = 0;
  int acc_edge = 0;
  logic prev_ov = 1'b0;
  logic prev_hs = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  function automatic int exp_lat(input int bv);
`ifdef MOD_MULT_FAST_EN
    int p;
    p = $countones(8'(bv));
    return 1 + 4 * p + 2 * (8 - p);
`else
    return FIXED_LAT;
`endif
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  initial forever begin
    @(posedge clk);
    #1;
    case (or_mode)
      0: out_ready = 1'b1;
      1: out_ready = 1'b0;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: latency is counted in cycles with the acceptance cycle as cycle 0.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_ov = 1'b0;
      prev_hs = 1'b0;
    end else begin
      if (prev_hs) check("pulse_drop", 32'(out_valid), 32'd0);
      if (in_valid && in_ready) acc_edge = cyc + 1;
      if (out_valid && !prev_ov) begin
        if (exp_lat_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_out: got out_valid=1, expected no pending op");
        end else begin
          check("latency", 32'(cyc - acc_edge + 1), 32'(exp_lat_q.pop_front()));
        end
      end
      if (out_valid && exp_res_q.size() != 0) begin
        check("result", 32'(result), 32'(exp_res_q[0]));
        check("in_ready_busy", 32'(in_ready), 32'd0);
        if (out_ready) void'(exp_res_q.pop_front());
      end
      prev_hs = out_valid && out_ready;
      prev_ov = out_valid;
    end
  end

  task automatic issue(input int ia, input int ib, input int inn);
    int w;
    exp_res_q.push_back((ia * ib) % inn);
    exp_lat_q.push_back(exp_lat(ib));
    a = 8'(ia);
    b = 8'(ib);
    n = 8'(inn);
    in_valid = 1'b1;
    w = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      w++;
      if (w > 300) break;
    end
    if (w > 300) begin
      n_tests++;
      n_fail++;
      $display("FAIL accept_timeout: got in_ready=0, expected 1 within 300 cycles");
      void'(exp_res_q.pop_back());
      void'(exp_lat_q.pop_back());
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      a = 8'($urandom);
      b = 8'($urandom);
      n = 8'($urandom);
    end
  endtask

  task automatic wait_done();
    int w;
    w = 0;
    while (exp_res_q.size() != 0 && w < 500) begin
      @(posedge clk);
      w++;
    end
    if (exp_res_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL done_timeout: got %0d pending results, expected 0", exp_res_q.size());
      exp_res_q.delete();
      exp_lat_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no completion, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int na, nb, nn;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    rst_n = 1'b1;
    or_mode = 0;
    @(posedge clk);
    #1;

    issue(7, 11, 13);
    wait_done();
    issue(12, 12, 143);
    wait_done();
    issue(0, 9, 10);
    issue(9, 0, 10);
    wait_done();

    // Backpressure: result must stay put and no new operand may be taken.
    or_mode = 1;
    @(posedge clk);
    #1;
    issue(5, 5, 33);
    begin
      int w;
      w = 0;
      while (!out_valid && w < 100) begin
        @(posedge clk);
        #1;
        w++;
      end
      check("bp_out_valid", 32'(out_valid), 32'd1);
    end
    in_valid = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("bp_hold_valid", 32'(out_valid), 32'd1);
    check("bp_hold_result", 32'(result), 32'd25);
    or_mode = 0;
    wait_done();
    check("bp_idle", 32'(in_ready), 32'd1);

    // Reset mid-operation discards the op.
    issue(7, 11, 13);
    repeat (14) @(posedge clk);
    #1;
    rst_n = 1'b0;
    exp_res_q.delete();
    exp_lat_q.delete();
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_result", 32'(result), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    issue(3, 4, 13);
    wait_done();

    or_mode = 2;
    for (int k = 0; k < 60; k++) begin
      nn = $urandom_range(2, 255);
      na = $urandom_range(0, nn - 1);
      nb = $urandom_range(0, nn - 1);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      issue(na, nb, nn);
    end
    wait_done();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
